// File: rtl/framebuffer_scanout_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : typhoon_pkg
// Description : Shared types and raster constants for the framebuffer scanout.
// Revision    : 1.0 - initial release
// ============================================================================
package typhoon_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int FB_PIXELS = H_RES * V_RES;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/framebuffer_scanout_reader_scanout_fifo.sv
`default_nettype none
// ============================================================================
// Module      : scanout_fifo
// Description : Synchronous prefetch FIFO with flush; pop of an empty FIFO is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module scanout_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [AW:0]      cnt_q;
    logic             do_pop;

    assign do_pop = pop_i && (cnt_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            case ({push_i, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/framebuffer_scanout_reader.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_scanout_reader
// Description : Prefetches RGB565 pixels from SRAM and delivers RGB888 per pixel strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_scanout_reader #(
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [19:0] BUF1_BASE  = 20'd307200
) (
    input  logic        BOARD_CLK,
    input  logic        Reset,
    input  logic        frameStart,
    input  logic        pixelStrobe,
    input  logic        doubleBuffer,
    output logic [19:0] framebufferAddress,
    output logic        queueRead,
    input  logic        dataReady,
    input  logic [15:0] framebufferData,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        underflow
);
    import typhoon_pkg::*;

    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int PIXELS = H_RES * V_RES;

    scan_state_t state_q, state_d;
    logic [19:0] addr_q, addr_d;
    logic [19:0] count_q, count_d;
    logic        req_q, req_d;
    logic        buf_q, buf_d;
    logic [7:0]  r_q, g_q, b_q;
    logic        underflow_q;

    logic          fifo_push;
    logic          fifo_flush;
    logic          fifo_empty;
    logic [15:0]   fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] used;
    logic          has_free;
    logic          buf_sel;
    logic [19:0]   base;
    rgb565_t       px;

    scanout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk_i   (BOARD_CLK),
        .rst_i   (Reset),
        .push_i  (fifo_push),
        .pop_i   (pixelStrobe),
        .flush_i (fifo_flush),
        .din_i   (framebufferData),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // An outstanding request reserves a slot so the FIFO can never overflow.
    assign used     = fifo_count + CW'(req_q);
    assign has_free = (used < CW'(FIFO_DEPTH));
    assign buf_sel  = frameStart ? doubleBuffer : buf_q;
    assign base     = buf_sel ? BUF1_BASE : 20'd0;
    assign px       = fifo_dout;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        req_d      = req_q;
        buf_d      = buf_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            WAIT: begin
                if (frameStart) buf_d = doubleBuffer;
                if (dataReady) begin
                    req_d   = 1'b0;
                    state_d = FILL;
                    if (frameStart) begin
                        // Word answers the abandoned frame: drop it and restart at once.
                        fifo_flush = 1'b1;
                        addr_d     = base;
                        count_d    = '0;
                    end else begin
                        fifo_push = 1'b1;
                        addr_d    = addr_q + 20'd1;
                        count_d   = count_q + 20'd1;
                    end
                end else if (frameStart) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (frameStart) begin
                    buf_d      = doubleBuffer;
                    fifo_flush = 1'b1;
                end
                if (dataReady) begin
                    req_d      = 1'b0;
                    fifo_flush = 1'b1;
                    addr_d     = base;
                    count_d    = '0;
                    state_d    = FILL;
                end
            end
            default: begin
                if (frameStart) begin
                    buf_d      = doubleBuffer;
                    fifo_flush = 1'b1;
                    addr_d     = base;
                    count_d    = '0;
                    state_d    = FILL;
                end else if (state_q == FILL) begin
                    if (count_q == 20'(PIXELS)) begin
                        state_d = DONE;
                    end else if (has_free) begin
                        req_d   = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge BOARD_CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            req_q   <= 1'b0;
            buf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            req_q   <= req_d;
            buf_q   <= buf_d;
        end
    end

    always_ff @(posedge BOARD_CLK or posedge Reset) begin
        if (Reset) begin
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            underflow_q <= 1'b0;
        end else if (pixelStrobe) begin
            if (fifo_empty) begin
                r_q         <= 8'hFF;
                g_q         <= 8'h00;
                b_q         <= 8'hFF;
                underflow_q <= 1'b1;
            end else begin
                r_q <= {px.r, px.r[4:2]};
                g_q <= {px.g, px.g[5:4]};
                b_q <= {px.b, px.b[4:2]};
            end
        end
    end

    assign framebufferAddress = addr_q;
    assign queueRead          = req_q;
    assign R                  = r_q;
    assign G                  = g_q;
    assign B                  = b_q;
    assign underflow          = underflow_q;

endmodule
`default_nettype wire
